// File: rtl/div_seq.sv
// Iterative radix-2 restoring unsigned divider behind valid/ready, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN skips the dividend's leading zeros to shorten latency.
module div_seq #(
    parameter int K  = 32,
    parameter int QW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [K+QW-1:0] x,
    input  logic [K-1:0]    d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   q,
    output logic [K-1:0]    r,
    output logic            dz,
    output logic            ovf
);
    localparam int W  = K + QW;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  xs_q, xs_d;
    logic [K-1:0]  d_q, d_d;
    logic [K-1:0]  rem_q, rem_d;
    logic [QW-1:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
    logic          accept;
    logic [K:0]    acc_sh;
    logic [K-1:0]  acc_sub;
    logic          ge;

`ifdef DIV_EARLY_OUT_EN
    function automatic logic [CW-1:0] lead_zeros(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (v[i]) n = CW'(W - 1 - i);
        end
        return n;
    endfunction

    logic [CW-1:0] lz;
    assign lz = lead_zeros(x);
`endif

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign r         = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

    // The partial remainder is always below d, so only the shifted value needs the extra bit.
    assign acc_sh  = {rem_q, xs_q[W-1]};
    assign ge      = (acc_sh >= {1'b0, d_q});
    assign acc_sub = acc_sh[K-1:0] - d_q;

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        d_d     = d_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    d_d   = d;
                    dz_d  = (d == '0);
                    ovf_d = (x[W-1:QW] >= d);
                    rem_d = '0;
                    q_d   = '0;
                    if (d == '0) begin
                        q_d     = '1;
                        rem_d   = x[K-1:0];
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
`ifdef DIV_EARLY_OUT_EN
                        xs_d    = x << lz;
                        cnt_d   = CW'(W) - lz;
                        state_d = (lz == CW'(W)) ? S_DONE : S_BUSY;
`else
                        xs_d    = x;
                        cnt_d   = CW'(W);
                        state_d = S_BUSY;
`endif
                    end
                end
            end
            S_BUSY: begin
                rem_d = ge ? acc_sub : acc_sh[K-1:0];
                q_d   = QW'({q_q, ge});
                xs_d  = xs_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand shadows only matter while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        xs_q <= xs_d;
        d_q  <= d_d;
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq (K=QW=32): arithmetic/cycle model checked every cycle plus directed literal vectors.
module tb_div_seq;
    localparam int K  = 32;
    localparam int QW = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, dz, ovf;
    logic [63:0] x;
    logic [31:0] d, q, r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_seq #(.K(K), .QW(QW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .dz(dz), .ovf(ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Arithmetic contract: quotient modulo 2^32, overflow when the true quotient needs more bits.
    function automatic void model(input logic [63:0] xx, input logic [31:0] dd,
                                  output logic [31:0] mq, output logic [31:0] mr,
                                  output logic mdz, output logic movf);
        logic [63:0] qf, rf;
        if (dd == 32'd0) begin
            mq = 32'hFFFF_FFFF; mr = xx[31:0]; mdz = 1'b1; movf = 1'b1;
        end else begin
            qf = xx / {32'd0, dd};
            rf = xx % {32'd0, dd};
            mq = qf[31:0]; mr = rf[31:0]; mdz = 1'b0; movf = (qf[63:32] != 32'd0);
        end
    endfunction

    // Edges after the acceptance edge until out_valid is seen (0 = done straight from acceptance).
    function automatic int exp_lat(input logic [63:0] xx, input logic [31:0] dd);
        if (dd == 32'd0) return 0;
`ifdef DIV_EARLY_OUT_EN
        for (int i = 63; i >= 0; i--) if (xx[i]) return i + 1;
        return 0;
`else
        return 64;
`endif
    endfunction

    // Cycle model: ph 0=idle, 1=busy, 2=done. Sampled at negedge, values as seen at the next posedge.
    int          m_ph = 0, m_left = 0;
    bit          m_known = 1'b0, m_zero = 1'b0;
    logic [31:0] m_q, m_r;
    logic        m_dz, m_ovf;

    always @(negedge clk) begin
        if (m_known) begin
            check("in_ready", in_ready, (m_ph == 0) && !rst);
            check("out_valid", out_valid, m_ph == 2);
            if (m_ph == 2) begin
                check("q", q, m_q);
                check("r", r, m_r);
                check("dz", dz, m_dz);
                check("ovf", ovf, m_ovf);
            end else if (m_zero) begin
                check("q_rstval", q, 0);
                check("r_rstval", r, 0);
                check("flags_rstval", {dz, ovf}, 0);
            end
        end
        if (rst) begin
            m_known = 1'b1; m_ph = 0; m_zero = 1'b1;
        end else if (m_known) begin
            case (m_ph)
                0: if (in_valid) begin
                    model(x, d, m_q, m_r, m_dz, m_ovf);
                    m_zero = 1'b0;
                    m_left = exp_lat(x, d);
                    m_ph   = (m_left == 0) ? 2 : 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_ph = 2;
                end
                default: if (out_ready) m_ph = 0;
            endcase
        end
    end

    task automatic send(input logic [63:0] xx, input logic [31:0] dd, input int stall,
                        output logic [31:0] gq, output logic [31:0] gr,
                        output logic gdz, output logic govf, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!in_ready) timeout("wait_in_ready");
        x = xx; d = dd; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = {$urandom, $urandom}; d = $urandom;
        lat = 0; guard = 0;
        while (!out_valid && guard < 200) begin @(posedge clk); #1; lat++; guard++; end
        if (!out_valid) timeout("wait_out_valid");
        gq = q; gr = r; gdz = dz; govf = ovf;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic vec(input string name, input logic [63:0] xx, input logic [31:0] dd,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eovf, input int elat);
        logic [31:0] gq, gr;
        logic        gdz, govf;
        int          lat;
        send(xx, dd, 0, gq, gr, gdz, govf, lat);
        check({name, "_q"}, gq, eq);
        check({name, "_r"}, gr, er);
        check({name, "_dz"}, gdz, edz);
        check({name, "_ovf"}, govf, eovf);
        check({name, "_lat"}, lat, elat);
    endtask

`ifdef DIV_EARLY_OUT_EN
    localparam int L100 = 7,  LMAX = 64, L5S = 35, L9 = 4,  LZERO = 0;
`else
    localparam int L100 = 64, LMAX = 64, L5S = 64, L9 = 64, LZERO = 64;
`endif

    initial begin
        logic [31:0] pq, pr, gq, gr;
        logic        pdz, povf, gdz, govf;
        logic [63:0] rx;
        logic [31:0] rd;
        int          lat, guard;

        // Pin the model against hand-computed values.
        model(64'd100, 32'd7, pq, pr, pdz, povf);
        check("model_100_7", {pq, pr}, {32'd14, 32'd2});
        check("model_100_7_flags", {pdz, povf}, 2'b00);
        model(64'h0000_0005_0000_0000, 32'd6, pq, pr, pdz, povf);
        check("model_5s_6", {pq, pr}, {32'hD555_5555, 32'd2});
        model(64'h1234_5678_9ABC_DEF0, 32'd0, pq, pr, pdz, povf);
        check("model_dz", {pq, pr}, {32'hFFFF_FFFF, 32'h9ABC_DEF0});
        check("model_dz_flags", {pdz, povf}, 2'b11);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; d = '0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_qr", {q, r}, 0);
        rst = 1'b0; #1;
        check("post_rst_in_ready", in_ready, 1);

        vec("v100_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, L100);
        vec("vmax_1", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LMAX);
        vec("v5s_6", 64'h0000_0005_0000_0000, 32'd6, 32'hD555_5555, 32'd2, 1'b0, 1'b0, L5S);
        vec("vdz", 64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b1, 0);
        vec("vzero", 64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, LZERO);

        // Backpressure: result holds, new requests are ignored.
        out_ready = 1'b0; x = 64'd100; d = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; guard = 0;
        while (!out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!out_valid) timeout("bp_wait_out_valid");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1)); x = {$urandom, $urandom}; d = $urandom;
            @(posedge clk); #1;
            check("bp_q", q, 14);
            check("bp_r", r, 2);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);

        // Abort mid-operation.
        x = 64'hDEAD_BEEF_0123_4567; d = 32'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        check("busy_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_qr", {q, r}, 0);
        vec("v9_3", 64'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, L9);

        // Random operands with occasional stalls; the model process checks every result.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rx = {$urandom, $urandom};
                1: rx = {32'd0, $urandom};
                2: rx = {32'($urandom_range(0, 15)), $urandom};
                default: rx = 64'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 7))
                0: rd = 32'd0;
                1, 2: rd = 32'($urandom_range(1, 16));
                default: rd = $urandom;
            endcase
            send(rx, rd, $urandom_range(0, 2), gq, gr, gdz, govf, lat);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
